comp_arbiter: RTL and testbench
===============================

# comp_arbiter

Shares one equality comparator (the 3-bit a/b equality lane used elsewhere in the design) among NREQ requesters. Each requester presents an operand pair with a request line; the block arbitrates, steers the winner's operands onto the shared comparator, registers the equality result and returns it tagged with the requester index over a valid/ready response port. It sits between requesting datapath units and a single combinational comparator instance.

## Interface
- NREQ, 4: number of requesters, 2..8.
- WIDTH, 3: operand width.
- IDW, 2: response ID width, must equal clog2(NREQ).

- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- req  in  NREQ  request per requester; held with operands until own gnt bit seen.
- req_a  in  NREQ*WIDTH  first operands, requester i at [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  second operands, same packing.
- gnt  out  NREQ  one-hot, one-cycle pulse: operands of that requester captured.
- cmp_x  out  WIDTH  operand to shared comparator.
- cmp_y  out  WIDTH  operand to shared comparator.
- cmp_eq  in  1  comparator result (cmp_x == cmp_y), combinational.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumer accepts.
- rsp_id  out  IDW  index of requester the response belongs to.
- rsp_eq  out  1  1 = operands equal.
- busy  out  1  state != IDLE.

## Operation
- States: IDLE, ISSUE, RESP. Reset state IDLE.
- IDLE: if req != 0, select winner (round-robin from ptr: first set bit at index ptr, ptr+1, ... wrapping mod NREQ); capture winner's req_a/req_b into op_x/op_y, winner index into id_q; go ISSUE. If req == 0, stay.
- ISSUE: gnt[id_q]=1 for this cycle only; cmp_x/cmp_y driven from op_x/op_y; cmp_eq sampled into eq_q at end of cycle; go RESP.
- RESP: rsp_valid=1, rsp_id=id_q, rsp_eq=eq_q, all stable until handshake. On rsp_valid & rsp_ready: ptr <= (id_q+1) mod NREQ, go IDLE. Otherwise stay.
- cmp_x/cmp_y hold op_x/op_y in all states (no toggling outside capture).
- req ignored in ISSUE and RESP; new requests or operand changes there have no effect.
- Pointer wrap: id_q = NREQ-1 sets ptr to 0.
- Requester deasserting req before its gnt: request is dropped if not yet captured; no gnt issued.

## Timing
- Reset values: gnt=0, cmp_x=0, cmp_y=0, rsp_valid=0, rsp_id=0, rsp_eq=0, busy=0, ptr=0, state IDLE.
- All outputs registered or decoded from registered state; no combinational path from req or rsp_ready to any output.
- Latency: req high at IDLE cycle c0 -> gnt at c1 -> rsp_valid at c2. With rsp_ready held high: back in IDLE at c3, throughput one operation per 3 cycles.
- Back-pressure: rsp_ready low holds RESP indefinitely; outputs unchanged.
- Reset asserted in any state: at next edge all state returns to reset values; in-flight operation discarded, no response and no further gnt emitted.
- Simultaneous requests: exactly one grant per arbitration; all others wait, no starvation under round-robin (each waits at most NREQ-1 operations).

## Configuration
- COMP_ARB_FIXED_PRIO_EN: defined -> fixed priority, lowest asserted index always wins, ptr unused (held 0). Not defined -> round-robin as in Operation. Latency, handshake and reset behaviour identical in both builds.

## Test plan
- Single request: reset, req=4'b0010, req_a[5:3]=3'd5, req_b[5:3]=3'd5, rsp_ready=1 -> gnt=4'b0010 at c1, rsp_valid at c2 with rsp_id=1, rsp_eq=1; busy low at c3.
- Mismatch: requester 0 a=3'd5, b=3'd6 -> rsp_id=0, rsp_eq=0; cmp_x=5, cmp_y=6 during ISSUE.
- Round-robin: req=4'b1111 held, each requester dropping req after its gnt and reasserting later -> grant order 0,1,2,3,0; under COMP_ARB_FIXED_PRIO_EN with all held -> 0 repeatedly.
- Back-pressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_id, rsp_eq stable all 5 cycles, no gnt; rsp_ready=1 -> IDLE next cycle.
- Wrap: last grant id 3 -> with req=4'b1001 next grant is 0.
- Reset mid-operation: reset asserted in ISSUE -> next cycle all outputs 0, state IDLE, no rsp_valid; following request granted normally from ptr 0.

Source files
------------

// File: rtl/comp_arbiter_if.sv
// Requester/response bundle for comp_arbiter: operand requests, shared comparator lane
// and tagged equality response.
interface comp_arbiter_if #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 3,
    parameter int unsigned IDW   = 2
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       gnt;
    logic [WIDTH-1:0]      cmp_x;
    logic [WIDTH-1:0]      cmp_y;
    logic                  cmp_eq;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic                  rsp_eq;
    logic                  busy;

    modport master (
        output req, req_a, req_b, cmp_eq, rsp_ready,
        input  gnt, cmp_x, cmp_y, rsp_valid, rsp_id, rsp_eq, busy
    );

    modport slave (
        input  req, req_a, req_b, cmp_eq, rsp_ready,
        output gnt, cmp_x, cmp_y, rsp_valid, rsp_id, rsp_eq, busy
    );
endinterface

// File: rtl/comp_arbiter.sv
// Shares one equality comparator among NREQ requesters; round-robin by default,
// fixed lowest-index priority when COMP_ARB_FIXED_PRIO_EN is defined.
module comp_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 3,
    parameter int unsigned IDW   = 2
) (
    input  logic          clk,
    input  logic          reset,
    comp_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

    state_t           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [WIDTH-1:0] op_x, op_x_d;
    logic [WIDTH-1:0] op_y, op_y_d;
    logic             eq_q, eq_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             busy_q, busy_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;

    logic             win_found;
    logic [IDW-1:0]   win_idx;
    logic [WIDTH-1:0] win_a;
    logic [WIDTH-1:0] win_b;
    int unsigned      scan;

    // Winner search: first asserted request starting at ptr (or at 0 for fixed priority)
    always_comb begin : arbitrate
        win_found = 1'b0;
        win_idx   = '0;
        win_a     = '0;
        win_b     = '0;
        scan      = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
`ifdef COMP_ARB_FIXED_PRIO_EN
            scan = k;
`else
            scan = 32'(ptr_q) + k;
            if (scan >= NREQ) begin
                scan = scan - NREQ;
            end
`endif
            if (!win_found && bus.req[IDW'(scan)]) begin
                win_found = 1'b1;
                win_idx   = IDW'(scan);
                win_a     = bus.req_a[scan*WIDTH +: WIDTH];
                win_b     = bus.req_b[scan*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin : next_state
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        op_x_d      = op_x;
        op_y_d      = op_y;
        eq_d        = eq_q;
        rsp_valid_d = rsp_valid_q;
        gnt_d       = '0;
        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    id_d    = win_idx;
                    op_x_d  = win_a;
                    op_y_d  = win_b;
                    gnt_d   = NREQ'(1) << win_idx;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                eq_d        = bus.cmp_eq;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
`ifdef COMP_ARB_FIXED_PRIO_EN
                    ptr_d = '0;
`else
                    ptr_d = (id_q == LAST_ID) ? '0 : IDW'(id_q + 1'b1);
`endif
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin : regs
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            op_x        <= '0;
            op_y        <= '0;
            eq_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            gnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            op_x        <= op_x_d;
            op_y        <= op_y_d;
            eq_q        <= eq_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
            gnt_q       <= gnt_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.cmp_x     = op_x;
    assign bus.cmp_y     = op_y;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = id_q;
    assign bus.rsp_eq    = eq_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_comp_arbiter.sv
// Self-checking bench for comp_arbiter: scoreboard of expected (id, eq) pairs
// pushed at request time and popped when the response appears.
module tb_comp_arbiter;
    localparam int unsigned NREQ  = 4;
    localparam int unsigned WIDTH = 3;
    localparam int unsigned IDW   = 2;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic           eq;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    exp_t sb[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    comp_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) bus ();

    // The shared combinational comparator this block steers onto
    assign bus.cmp_eq = (bus.cmp_x == bus.cmp_y);

    comp_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int idx, input logic [2:0] a, input logic [2:0] b);
        bus.req_a[idx*WIDTH +: WIDTH] = a;
        bus.req_b[idx*WIDTH +: WIDTH] = b;
    endtask

    task automatic wait_gnt(output logic [3:0] g, output bit ok);
        ok = 1'b0;
        g  = '0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus.gnt != 4'b0) begin
                g  = bus.gnt;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_rsp(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus.rsp_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [14:0] obs;
        reset         = 1'b1;
        bus.req       = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b1;
        step();
        step();
        obs = {bus.gnt, bus.cmp_x, bus.cmp_y, bus.rsp_valid, bus.rsp_id, bus.rsp_eq, bus.busy};
        tests_run++;
        if (obs !== 15'b0) begin
            tests_failed++;
            $display("FAIL reset_values: got %b, want all zero", obs);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_round_robin();
        int         exp_ids[5];
        logic [3:0] g;
        logic [3:0] exp_g;
        bit         ok;
        exp_t       e;
`ifdef COMP_ARB_FIXED_PRIO_EN
        exp_ids = '{0, 0, 0, 0, 0};
`else
        exp_ids = '{0, 1, 2, 3, 0};
`endif
        for (int i = 0; i < 4; i++) begin
            set_ops(i, 3'(i + 1), (i == 2) ? 3'(i + 2) : 3'(i + 1));
        end
        bus.req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            sb.push_back('{id: IDW'(exp_ids[n]), eq: (exp_ids[n] != 2)});
            exp_g = 4'(1 << exp_ids[n]);
            wait_gnt(g, ok);
            tests_run++;
            if (!ok || g !== exp_g) begin
                tests_failed++;
                $display("FAIL rr_grant[%0d]: got %b (seen=%0d), want %b", n, g, ok, exp_g);
            end
            bus.req = bus.req & ~g;
            wait_rsp(ok);
            e = sb.pop_front();
            tests_run++;
            if (!ok || bus.rsp_id !== e.id || bus.rsp_eq !== e.eq) begin
                tests_failed++;
                $display("FAIL rr_rsp[%0d]: got id=%0d eq=%b (seen=%0d), want id=%0d eq=%b",
                         n, bus.rsp_id, bus.rsp_eq, ok, e.id, e.eq);
            end
            bus.req = 4'b1111;
        end
        bus.req = '0;
        step();
    endtask

    task automatic test_single();
        exp_t e;
        set_ops(1, 3'd5, 3'd5);
        bus.req = 4'b0010;
        sb.push_back('{id: 2'd1, eq: 1'b1});
        step();
        tests_run++;
        if (bus.gnt !== 4'b0010 || bus.busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_gnt: got gnt=%b busy=%b, want gnt=0010 busy=1", bus.gnt, bus.busy);
        end
        bus.req = '0;
        step();
        e = sb.pop_front();
        tests_run++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== e.id || bus.rsp_eq !== e.eq || bus.gnt !== 4'b0) begin
            tests_failed++;
            $display("FAIL single_rsp: got valid=%b id=%0d eq=%b gnt=%b, want valid=1 id=%0d eq=%b gnt=0000",
                     bus.rsp_valid, bus.rsp_id, bus.rsp_eq, bus.gnt, e.id, e.eq);
        end
        step();
        tests_run++;
        if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_idle: got busy=%b valid=%b, want 0 0", bus.busy, bus.rsp_valid);
        end
    endtask

    task automatic test_mismatch();
        exp_t e;
        set_ops(0, 3'd5, 3'd6);
        bus.req = 4'b0001;
        sb.push_back('{id: 2'd0, eq: 1'b0});
        step();
        tests_run++;
        if (bus.gnt !== 4'b0001 || bus.cmp_x !== 3'd5 || bus.cmp_y !== 3'd6) begin
            tests_failed++;
            $display("FAIL mismatch_issue: got gnt=%b x=%0d y=%0d, want gnt=0001 x=5 y=6",
                     bus.gnt, bus.cmp_x, bus.cmp_y);
        end
        // operand change after capture must not reach the comparator
        set_ops(0, 3'd6, 3'd6);
        bus.req = '0;
        step();
        e = sb.pop_front();
        tests_run++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== e.id || bus.rsp_eq !== e.eq) begin
            tests_failed++;
            $display("FAIL mismatch_rsp: got valid=%b id=%0d eq=%b, want valid=1 id=%0d eq=%b",
                     bus.rsp_valid, bus.rsp_id, bus.rsp_eq, e.id, e.eq);
        end
        step();
    endtask

    task automatic test_back_pressure();
        exp_t e;
        bus.rsp_ready = 1'b0;
        set_ops(2, 3'd3, 3'd3);
        bus.req = 4'b0100;
        sb.push_back('{id: 2'd2, eq: 1'b1});
        step();
        bus.req = '0;
        step();
        e = sb.pop_front();
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== e.id || bus.rsp_eq !== e.eq || bus.gnt !== 4'b0) begin
                tests_failed++;
                $display("FAIL backpressure[%0d]: got valid=%b id=%0d eq=%b gnt=%b, want valid=1 id=%0d eq=%b gnt=0000",
                         i, bus.rsp_valid, bus.rsp_id, bus.rsp_eq, bus.gnt, e.id, e.eq);
            end
            step();
        end
        bus.rsp_ready = 1'b1;
        step();
        tests_run++;
        if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL backpressure_release: got busy=%b valid=%b, want 0 0", bus.busy, bus.rsp_valid);
        end
    endtask

    task automatic test_wrap();
        logic [3:0] g;
        bit         ok;
        exp_t       e;
        set_ops(3, 3'd7, 3'd7);
        set_ops(0, 3'd2, 3'd2);
        bus.req = 4'b1000;
        sb.push_back('{id: 2'd3, eq: 1'b1});
        wait_gnt(g, ok);
        tests_run++;
        if (!ok || g !== 4'b1000) begin
            tests_failed++;
            $display("FAIL wrap_gnt3: got %b (seen=%0d), want 1000", g, ok);
        end
        bus.req = '0;
        wait_rsp(ok);
        e = sb.pop_front();
        tests_run++;
        if (!ok || bus.rsp_id !== e.id || bus.rsp_eq !== e.eq) begin
            tests_failed++;
            $display("FAIL wrap_rsp3: got id=%0d eq=%b (seen=%0d), want id=%0d eq=%b",
                     bus.rsp_id, bus.rsp_eq, ok, e.id, e.eq);
        end
        bus.req = 4'b1001;
        sb.push_back('{id: 2'd0, eq: 1'b1});
        wait_gnt(g, ok);
        tests_run++;
        if (!ok || g !== 4'b0001) begin
            tests_failed++;
            $display("FAIL wrap_gnt0: got %b (seen=%0d), want 0001", g, ok);
        end
        bus.req = '0;
        wait_rsp(ok);
        e = sb.pop_front();
        tests_run++;
        if (!ok || bus.rsp_id !== e.id || bus.rsp_eq !== e.eq) begin
            tests_failed++;
            $display("FAIL wrap_rsp0: got id=%0d eq=%b (seen=%0d), want id=%0d eq=%b",
                     bus.rsp_id, bus.rsp_eq, ok, e.id, e.eq);
        end
        step();
    endtask

    task automatic test_reset_mid();
        logic [14:0] obs;
        logic [3:0]  g;
        bit          ok;
        bit          spurious;
        exp_t        e;
        set_ops(2, 3'd1, 3'd1);
        bus.req = 4'b0100;
        step();
        tests_run++;
        if (bus.gnt !== 4'b0100) begin
            tests_failed++;
            $display("FAIL midreset_gnt: got %b, want 0100", bus.gnt);
        end
        reset   = 1'b1;
        bus.req = '0;
        step();
        obs = {bus.gnt, bus.cmp_x, bus.cmp_y, bus.rsp_valid, bus.rsp_id, bus.rsp_eq, bus.busy};
        tests_run++;
        if (obs !== 15'b0) begin
            tests_failed++;
            $display("FAIL midreset_values: got %b, want all zero", obs);
        end
        reset    = 1'b0;
        spurious = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (bus.rsp_valid !== 1'b0 || bus.gnt !== 4'b0) spurious = 1'b1;
        end
        tests_run++;
        if (spurious !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_quiet: got spurious gnt/rsp=%b, want 0", spurious);
        end
        set_ops(0, 3'd4, 3'd1);
        bus.req = 4'b1111;
        sb.push_back('{id: 2'd0, eq: 1'b0});
        wait_gnt(g, ok);
        tests_run++;
        if (!ok || g !== 4'b0001) begin
            tests_failed++;
            $display("FAIL midreset_regrant: got %b (seen=%0d), want 0001", g, ok);
        end
        bus.req = '0;
        wait_rsp(ok);
        e = sb.pop_front();
        tests_run++;
        if (!ok || bus.rsp_id !== e.id || bus.rsp_eq !== e.eq) begin
            tests_failed++;
            $display("FAIL midreset_rsp: got id=%0d eq=%b (seen=%0d), want id=%0d eq=%b",
                     bus.rsp_id, bus.rsp_eq, ok, e.id, e.eq);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_mismatch();
        test_back_pressure();
        test_wrap();
        test_reset_mid();
        tests_run++;
        if (sb.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
